// File: rtl/pkg_tpu.sv
// Shared vector-lane types: write-back source ids, token and data formats.
// The arbiter uses the token only as an opaque payload of $bits(pipe_exe_tmp_t).
package pkg_tpu;

    localparam int WB_NUM_SRC = 4;

    typedef enum logic [1:0] {
        WB_LDST1 = 2'd0,
        WB_LDST2 = 2'd1,
        WB_MATH  = 2'd2,
        WB_MV    = 2'd3
    } wb_src_t;

    typedef logic [31:0] data_t;

    // issue_no lets the register file resolve ordering across sources
    typedef struct packed {
        logic [15:0] issue_no;
        logic [7:0]  dst_reg;
        logic [7:0]  lane_mask;
        logic [31:0] aux;
    } pipe_exe_tmp_t;

    // Next round-robin start position after a grant, modulo the number of sources.
    function automatic logic [1:0] rr_after(input logic [1:0] grant, input int num_src);
        logic [1:0] nxt;
        nxt = 2'((32'(grant) + 32'd1) % 32'(num_src));
        return nxt;
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source write-back FIFO; a write while full is accepted when a read happens in the same cycle.
module wb_src_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 96
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   I_We,
    input  logic                   I_Re,
    input  logic [W-1:0]           I_Data,
    output logic [W-1:0]           O_Data,
    output logic                   O_Full,
    output logic                   O_Empty,
    output logic [$clog2(DEPTH):0] O_Count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_we;
    logic          do_re;

    assign O_Full  = (count == (AW+1)'(DEPTH));
    assign O_Empty = (count == '0);
    assign O_Count = count;
    assign O_Data  = mem[rd_ptr];

    assign do_re = I_Re & ~O_Empty;
    assign do_we = I_We & (~O_Full | do_re);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_we) wr_ptr <= wr_ptr + 1'b1;
            if (do_re) rd_ptr <= rd_ptr + 1'b1;
            case ({do_we, do_re})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; count and pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (do_we) mem[wr_ptr] <= I_Data;
    end

endmodule

// File: rtl/wb_arbiter_v.sv
// Vector-lane write-back arbiter: per-source FIFOs, round-robin grant into a registered
// register-file write request, early stall for in-flight MA results, sticky overflow flags.
import pkg_tpu::*;

module wb_arbiter_v #(
    parameter int NUM_SRC  = WB_NUM_SRC,
    parameter int DEPTH    = 8,
    parameter int TOKEN_W  = $bits(pipe_exe_tmp_t),
    parameter int DATA_W   = $bits(data_t),
    parameter int STALL_HR = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SRC-1:0]     I_Valid,
    input  logic [NUM_SRC*TOKEN_W-1:0] I_Token,
    input  logic [NUM_SRC*DATA_W-1:0]  I_Data,
    input  logic                   I_WB_Ready,
    output logic                   O_WB_Valid,
    output logic [TOKEN_W-1:0]     O_WB_Token,
    output logic [DATA_W-1:0]      O_WB_Data,
    output logic [1:0]             O_WB_Src,
    output logic                   O_Stall,
    output logic [NUM_SRC-1:0]     O_Overflow,
    output logic                   O_Idle
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int FW    = TOKEN_W + DATA_W;

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [FW-1:0]      head  [NUM_SRC];
    logic [CNT_W-1:0]   count [NUM_SRC];

    logic       advance;
    logic       grant_vld;
    logic [1:0] grant;
    logic [1:0] idx;
    logic [1:0] rr_ptr;

    assign advance = ~O_WB_Valid | I_WB_Ready;

    genvar i;
    generate
        for (i = 0; i < NUM_SRC; i++) begin : g_fifo
            wb_src_fifo #(
                .DEPTH (DEPTH),
                .W     (FW)
            ) u_fifo (
                .clock   (clock),
                .reset   (reset),
                .I_We    (push[i]),
                .I_Re    (pop[i]),
                .I_Data  ({I_Token[i*TOKEN_W +: TOKEN_W], I_Data[i*DATA_W +: DATA_W]}),
                .O_Data  (head[i]),
                .O_Full  (full[i]),
                .O_Empty (empty[i]),
                .O_Count (count[i])
            );
        end
    endgenerate

    // First non-empty FIFO at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = 2'((32'(rr_ptr) + k) % 32'(NUM_SRC));
            if (!grant_vld && !empty[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (advance && grant_vld) pop[grant] = 1'b1;
    end

    // A push into a full FIFO survives only when that FIFO pops in the same cycle.
    assign push = I_Valid & (~full | pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            O_WB_Valid <= 1'b0;
            O_WB_Token <= '0;
            O_WB_Data  <= '0;
            O_WB_Src   <= '0;
            rr_ptr     <= '0;
        end else if (advance) begin
            if (grant_vld) begin
                O_WB_Valid <= 1'b1;
                O_WB_Token <= head[grant][FW-1:DATA_W];
                O_WB_Data  <= head[grant][DATA_W-1:0];
                O_WB_Src   <= grant;
                rr_ptr     <= rr_after(grant, NUM_SRC);
            end else begin
                O_WB_Valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            O_Overflow <= '0;
        end else begin
            O_Overflow <= O_Overflow | (I_Valid & full & ~pop);
        end
    end

    always_comb begin
        O_Stall = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (32'(count[k]) >= 32'(DEPTH - STALL_HR)) O_Stall = 1'b1;
        end
    end

    assign O_Idle = (&empty) & ~O_WB_Valid;

endmodule

// File: tb/tb_wb_arbiter_v.sv
// Directed bench for wb_arbiter_v: latency, round-robin order, backpressure, stall/overflow, full-pop-push, async reset.
module tb_wb_arbiter_v;

    localparam int NS = 4;
    localparam int TW = 64;
    localparam int DW = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [NS-1:0]     I_Valid;
    logic [NS*TW-1:0]  I_Token;
    logic [NS*DW-1:0]  I_Data;
    logic              I_WB_Ready;
    logic              O_WB_Valid;
    logic [TW-1:0]     O_WB_Token;
    logic [DW-1:0]     O_WB_Data;
    logic [1:0]        O_WB_Src;
    logic              O_Stall;
    logic [NS-1:0]     O_Overflow;
    logic              O_Idle;

    int checks = 0;
    int errors = 0;

    wb_arbiter_v #(
        .NUM_SRC  (4),
        .DEPTH    (8),
        .TOKEN_W  (64),
        .DATA_W   (32),
        .STALL_HR (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .I_Valid    (I_Valid),
        .I_Token    (I_Token),
        .I_Data     (I_Data),
        .I_WB_Ready (I_WB_Ready),
        .O_WB_Valid (O_WB_Valid),
        .O_WB_Token (O_WB_Token),
        .O_WB_Data  (O_WB_Data),
        .O_WB_Src   (O_WB_Src),
        .O_Stall    (O_Stall),
        .O_Overflow (O_Overflow),
        .O_Idle     (O_Idle)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] tok(input int src, input logic [31:0] d);
        return {32'hC0DE_0000 | 32'(src), d};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_push(input int src, input logic [31:0] d);
        I_Valid[src]            = 1'b1;
        I_Data[src*DW +: DW]    = d;
        I_Token[src*TW +: TW]   = tok(src, d);
    endtask

    task automatic expect_wb(input string tag, input int src, input logic [31:0] d);
        check({tag, ".valid"}, 64'(O_WB_Valid), 64'd1);
        check({tag, ".src"},   64'(O_WB_Src),   64'(src));
        check({tag, ".data"},  64'(O_WB_Data),  64'(d));
        check({tag, ".token"}, O_WB_Token,      tok(src, d));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".valid"}, 64'(O_WB_Valid), 64'd0);
        check({tag, ".token"}, O_WB_Token,      64'd0);
        check({tag, ".data"},  64'(O_WB_Data),  64'd0);
        check({tag, ".src"},   64'(O_WB_Src),   64'd0);
        check({tag, ".stall"}, 64'(O_Stall),    64'd0);
        check({tag, ".ovf"},   64'(O_Overflow), 64'd0);
        check({tag, ".idle"},  64'(O_Idle),     64'd1);
    endtask

    task automatic do_reset();
        I_Valid    = '0;
        I_Token    = '0;
        I_Data     = '0;
        I_WB_Ready = 1'b0;
        reset      = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        // 1: single push on src2, two-edge latency
        do_reset();
        check_reset_outputs("t1_reset");
        I_WB_Ready = 1'b1;
        set_push(2, 32'hA5A5_0001);
        tick();
        I_Valid = '0;
        check("t1_nobypass", 64'(O_WB_Valid), 64'd0);
        check("t1_busy",     64'(O_Idle),     64'd0);
        tick();
        expect_wb("t1_out", 2, 32'hA5A5_0001);
        tick();
        check("t1_drained", 64'(O_WB_Valid), 64'd0);
        check("t1_idle",    64'(O_Idle),     64'd1);

        // 2: all sources push together from rr_ptr=0
        do_reset();
        I_WB_Ready = 1'b1;
        for (int s = 0; s < NS; s++) set_push(s, 32'(s + 1));
        tick();
        I_Valid = '0;
        for (int s = 0; s < NS; s++) begin
            tick();
            expect_wb($sformatf("t2_g%0d", s), s, 32'(s + 1));
        end
        tick();
        check("t2_empty", 64'(O_WB_Valid), 64'd0);
        // rr_ptr back at 0: src0 wins over src1
        set_push(1, 32'h11);
        set_push(0, 32'h10);
        tick();
        I_Valid = '0;
        tick();
        expect_wb("t2_rr0", 0, 32'h10);
        tick();
        expect_wb("t2_rr1", 1, 32'h11);
        tick();
        check("t2_end", 64'(O_WB_Valid), 64'd0);

        // 3: backpressure holds the output on the first entry
        I_WB_Ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            set_push(0, 32'h30 + 32'(n));
            tick();
        end
        I_Valid = '0;
        for (int c = 0; c < 5; c++) begin
            expect_wb($sformatf("t3_hold%0d", c), 0, 32'h30);
            tick();
        end
        expect_wb("t3_hold5", 0, 32'h30);
        check("t3_notidle", 64'(O_Idle), 64'd0);
        I_WB_Ready = 1'b1;
        tick();
        expect_wb("t3_adv1", 0, 32'h31);
        tick();
        expect_wb("t3_adv2", 0, 32'h32);
        tick();
        check("t3_end", 64'(O_WB_Valid), 64'd0);

        // 4: src3 fills with output blocked; stall at 6, overflow on 9th push
        I_WB_Ready = 1'b0;
        set_push(0, 32'h40);
        tick();
        I_Valid = '0;
        tick();
        expect_wb("t4_blocker", 0, 32'h40);
        for (int n = 1; n <= 9; n++) begin
            set_push(3, 32'h300 + 32'(n));
            tick();
            check($sformatf("t4_stall%0d", n), 64'(O_Stall),       (n >= 6) ? 64'd1 : 64'd0);
            check($sformatf("t4_ovf%0d", n),   64'(O_Overflow[3]), (n >= 9) ? 64'd1 : 64'd0);
        end
        I_Valid = '0;
        I_WB_Ready = 1'b1;
        expect_wb("t4_first", 0, 32'h40);
        for (int n = 1; n <= 8; n++) begin
            tick();
            expect_wb($sformatf("t4_e%0d", n), 3, 32'h300 + 32'(n));
        end
        tick();
        check("t4_empty", 64'(O_WB_Valid), 64'd0);
        check("t4_nostall", 64'(O_Stall), 64'd0);
        check("t4_sticky", 64'(O_Overflow), 64'h8);

        // 5: full src1 pops and pushes in the same cycle
        I_WB_Ready = 1'b0;
        set_push(0, 32'h50);
        tick();
        I_Valid = '0;
        tick();
        for (int n = 1; n <= 8; n++) begin
            set_push(1, 32'h500 + 32'(n));
            tick();
        end
        I_Valid = '0;
        check("t5_full_stall", 64'(O_Stall), 64'd1);
        expect_wb("t5_blocker", 0, 32'h50);
        I_WB_Ready = 1'b1;
        set_push(1, 32'h5FF);
        tick();
        I_Valid = '0;
        expect_wb("t5_e1", 1, 32'h501);
        check("t5_noovf", 64'(O_Overflow), 64'h8);
        check("t5_stall_held", 64'(O_Stall), 64'd1);
        for (int n = 2; n <= 8; n++) begin
            tick();
            expect_wb($sformatf("t5_e%0d", n), 1, 32'h500 + 32'(n));
        end
        tick();
        expect_wb("t5_last", 1, 32'h5FF);
        tick();
        check("t5_end", 64'(O_WB_Valid), 64'd0);

        // 6: async reset mid-burst
        I_WB_Ready = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            set_push(2, 32'h60 + 32'(n));
            tick();
        end
        I_Valid = '0;
        expect_wb("t6_pre", 2, 32'h61);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        tick();
        reset = 1'b1;
        I_WB_Ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("t6_quiet%0d", c), 64'(O_WB_Valid), 64'd0);
        end
        check("t6_idle", 64'(O_Idle), 64'd1);
        set_push(0, 32'h70);
        tick();
        I_Valid = '0;
        tick();
        expect_wb("t6_new", 0, 32'h70);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
